partition_trace_capture: RTL
============================

# partition_trace_capture

Hardware-side consumer of partition-operation completions. Snoops the completion interface of the partition core (one pulse per finished PNEW/PSPLIT/PMERGE), timestamps each completion with a step number, buffers the records in a FIFO and streams them out as fixed-length 32-bit word records over a valid/ready port. This lets the design emit the same per-step trace (opcode, region, num_modules, μ-discovery/execution/total) that the Python VM isomorphism check consumes, without a simulator-side file writer.

## Interface
- FIFO_DEPTH, 8, record slots; power of two, ≥2
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  capture enable; when low, cap_valid is ignored
- cap_valid  in  1  one-cycle completion pulse (driven from core op_done)
- cap_opcode  in  8  0x00 PNEW, 0x01 PSPLIT, 0x02 PMERGE (others captured verbatim)
- cap_region  in  64  region/mask operand of the completed op
- cap_num_modules  in  8  module count after the op
- cap_mu_discovery  in  32  μ-discovery after the op
- cap_mu_execution  in  32  μ-execution after the op
- cap_mu_cost  in  32  μ-total after the op
- out_valid  out  1  a record word is presented
- out_data  out  32  record word
- out_last  out  1  high on word 5 of a record
- out_ready  in  1  sink accepts word when out_valid&&out_ready
- fifo_count  out  log2(FIFO_DEPTH)+1  records held, including the one being sent
- drop_count  out  16  records dropped on full FIFO, saturates at 0xFFFF

## Operation
- Capture: on a cycle with rst=0, enable=1, cap_valid=1, the record is built from the inputs and the current step counter; step then increments (16-bit, wraps 0xFFFF→0).
- Step increments on every enabled capture, including dropped ones, so dropped records show as gaps in the step field.
- Record layout, six words, sent in order: W0={step[15:0], opcode[7:0], num_modules[7:0]}; W1=region[31:0]; W2=region[63:32]; W3=mu_discovery; W4=mu_execution; W5=mu_cost.
- FIFO full: when fifo_count==FIFO_DEPTH and no pop occurs in the same cycle, the record is dropped and drop_count increments (saturating). Contents are unchanged.
- Pop occurs on the W5 handshake (out_valid&&out_ready&&out_last). A capture in that same cycle while full is accepted, not dropped; fifo_count stays at FIFO_DEPTH.
- Readout FSM: IDLE (out_valid=0, FIFO empty) → SEND (word index 0..5, out_valid=1) on FIFO non-empty. In SEND, index advances on each handshake. After the W5 handshake: → SEND with index 0 if the FIFO is still non-empty, else → IDLE.
- out_data/out_last are selected from the head FIFO entry by word index. They are stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake.
- Reset: all FIFO entries are discarded and step=0. Reset outranks any capture or handshake in the same cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, fifo_count=0, drop_count=0; internal step=0, word index=0, state IDLE.
- Capture-to-output latency with an empty FIFO: cap_valid sampled at edge N, so out_valid=1 with W0 after edge N (visible in cycle N+1).
- Throughput with out_ready held high: one word per cycle, six cycles per record, no bubble between back-to-back records.
- Back-to-back cap_valid pulses every cycle are legal; each one is either stored or dropped.
- fifo_count updates on the edge after a capture or pop. A simultaneous capture and pop leaves it unchanged.
- enable is sampled the same cycle as cap_valid. enable does not affect readout.

## Test plan
- Single PNEW: cap_opcode=0x00, region=0x7, num_modules=1, μ=(2,1,3) → out words 0x00000001, 0x7, 0x0, 2, 1, 3 with out_last only on the 6th word; fifo_count 1→0.
- Four-op sequence PNEW 0x7, PNEW 0x30, PSPLIT mask 0x1, PMERGE 0, with out_ready=1 → 24 words. W0 step fields 0,1,2,3, opcodes 00,00,01,02, no gaps.
- Backpressure: hold out_ready=0 for 10 cycles mid-record at W2 → out_data and out_last are stable. Release → W3..W5 follow on consecutive cycles.
- Overflow: out_ready=0 and 10 captures with FIFO_DEPTH=8 → fifo_count=8, drop_count=2. Drain → steps 0..7; next capture carries step 10.
- Full with simultaneous pop: FIFO full and W5 handshake in the same cycle as cap_valid → drop_count unchanged, fifo_count stays 8.
- Reset mid-record (after the W3 handshake) plus enable=0 behaviour → all outputs 0 next cycle. With enable=0, cap_valid captures nothing and step does not advance. The next enabled capture has step 0.

Source files
------------

// File: rtl/partition_trace_capture_if.sv
// rtl/partition_trace_capture_if.sv - capture, record-stream and status signals of partition_trace_capture
//
// Purpose: groups the completion snoop inputs, the 32-bit record word stream
//   and the occupancy/drop status into one bundle.
// Modports:
//   master - the trace capture block: takes enable/cap_*/out_ready,
//            drives out_valid/out_data/out_last/fifo_count/drop_count.
//   slave  - the environment (partition core + record sink), opposite directions.
interface partition_trace_capture_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          enable;
  logic          cap_valid;
  logic [7:0]    cap_opcode;
  logic [63:0]   cap_region;
  logic [7:0]    cap_num_modules;
  logic [31:0]   cap_mu_discovery;
  logic [31:0]   cap_mu_execution;
  logic [31:0]   cap_mu_cost;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_last;
  logic          out_ready;
  logic [CW-1:0] fifo_count;
  logic [15:0]   drop_count;

  modport master (
    input  enable, cap_valid, cap_opcode, cap_region, cap_num_modules,
           cap_mu_discovery, cap_mu_execution, cap_mu_cost, out_ready,
    output out_valid, out_data, out_last, fifo_count, drop_count
  );

  modport slave (
    output enable, cap_valid, cap_opcode, cap_region, cap_num_modules,
           cap_mu_discovery, cap_mu_execution, cap_mu_cost, out_ready,
    input  out_valid, out_data, out_last, fifo_count, drop_count
  );
endinterface

// File: rtl/partition_trace_capture.sv
// rtl/partition_trace_capture.sv - timestamps partition-op completions and streams them as 6-word records
//
// Purpose: each enabled cap_valid pulse becomes one record tagged with a
//   16-bit step number, held in a FIFO_DEPTH-entry FIFO and sent as six
//   32-bit words: {step,opcode,num_modules}, region lo, region hi,
//   mu_discovery, mu_execution, mu_cost. Records arriving on a full FIFO are
//   dropped and counted (saturating), but still consume a step number.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - partition_trace_capture_if.master (capture inputs, record stream, status)
module partition_trace_capture #(
  parameter int FIFO_DEPTH = 8
) (
  input logic                       clk,
  input logic                       rst,
  partition_trace_capture_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef logic [5:0][31:0] rec_t;
  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  rec_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   step_q, drop_q;
  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;

  logic  cap, send, hs, last_word, pop, full, push;
  rec_t  rec_in, head;
  logic [31:0] word;

  assign cap       = bus.enable & bus.cap_valid;
  assign send      = (state_q == ST_SEND);
  assign hs        = send & bus.out_ready;
  assign last_word = send & (idx_q == 3'd5);
  assign pop       = hs & last_word;
  assign full      = (count_q == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot the incoming record needs.
  assign push      = cap & (~full | pop);

  // Word 0 sits in the lowest lane so word n is simply lane n.
  assign rec_in = {bus.cap_mu_cost, bus.cap_mu_execution, bus.cap_mu_discovery,
                   bus.cap_region[63:32], bus.cap_region[31:0],
                   step_q, bus.cap_opcode, bus.cap_num_modules};

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // count_d is used so a record captured this cycle is presented right after
  // the edge, and a record pushed alongside a pop keeps SEND without a bubble.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (count_d != '0) begin
          state_d = ST_SEND;
          idx_d   = 3'd0;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (last_word) begin
            idx_d   = 3'd0;
            state_d = (count_d != '0) ? ST_SEND : ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    word = '0;
    case (idx_q)
      3'd0:    word = head[0];
      3'd1:    word = head[1];
      3'd2:    word = head[2];
      3'd3:    word = head[3];
      3'd4:    word = head[4];
      3'd5:    word = head[5];
      default: word = '0;
    endcase
  end

  assign bus.out_valid  = send;
  assign bus.out_data   = send ? word : 32'h0;
  assign bus.out_last   = last_word;
  assign bus.fifo_count = count_q;
  assign bus.drop_count = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      step_q   <= 16'd0;
      drop_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // Dropped captures still advance step, leaving a visible gap.
      if (cap) begin
        step_q <= step_q + 16'd1;
      end
      if (cap && !push && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  // Storage has no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= rec_in;
    end
  end
endmodule
